// File: rtl/cla_serial_add_ctrl_if.sv
// Handshake and data bundle for the nibble-serial adder/subtractor.
// master = operand producer / result consumer, slave = the controller.
interface cla_serial_add_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );
endinterface

// File: rtl/cla_serial_add_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract using a single 4-bit carry-lookahead
// slice, one nibble per cycle LSB first, carry chained through a register.

// 4-bit carry-lookahead slice.
module cla4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    // Generate/propagate and flattened lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ {c[3], c[2], c[1], cin};
        cout = c[4];
    end
endmodule

module cla_serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_serial_add_ctrl_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Holds the NIBBLES-1 finished nibbles; the last one comes straight off
    // the slice, so the register is one nibble short of WIDTH.
    logic [WIDTH-5:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [3:0]       slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] completed;

    cla4bit u_slice (
        .a    (a_q[3:0]),
        .b    (b_q[3:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    // Next-state, datapath sequencing and result capture.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        completed = {slice_s, res_q};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = (WIDTH-4)'(completed >> 4);
                carry_d = slice_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                    // a_q/b_q low nibble is the original top nibble here.
                    cout_d  = slice_co;
                    ovf_d   = (a_q[3] == b_q[3]) && (slice_s[3] != a_q[3]);
                    zero_d  = (completed == '0);
                    sum_d   = completed;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed bench for cla_serial_add_ctrl at WIDTH=32.
module tb_cla_serial_add_ctrl;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;

    cla_serial_add_ctrl_if #(.WIDTH(W)) bus ();

    cla_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic s);
        int guard;
        guard = 0;
        bus.a        = aa;
        bus.b        = bb;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("issue_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // edge = index of the first rising edge (accept edge = 0) that samples out_valid high.
    task automatic wait_result(output int edge_idx);
        edge_idx = 1;
        while (!bus.out_valid && edge_idx < 40) begin
            @(negedge clk);
            edge_idx++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] s,
                                input logic c, input logic o, input logic z);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".sum"},   64'(bus.sum),       64'(s));
        check({tag, ".cout"},  64'(bus.cout),      64'(c));
        check({tag, ".ovf"},   64'(bus.overflow),  64'(o));
        check({tag, ".zero"},  64'(bus.zero),      64'(z));
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vs [4];
    logic [31:0] es [4];
    logic        ec [4];
    logic        eo [4];
    logic        ez [4];

    initial begin
        int lat;
        int guard;
        int acc_edge;
        int prev_edge;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.in_ready",  64'(bus.in_ready),  64'd1);
        check("rst.sum",       64'(bus.sum),       64'd0);
        check("rst.cout",      64'(bus.cout),      64'd0);
        check("rst.ovf",       64'(bus.overflow),  64'd0);
        check("rst.zero",      64'(bus.zero),      64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: 1 + FFFFFFFF wraps to zero; latency check
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        check("t1.busy", 64'(bus.in_ready), 64'd0);
        wait_result(lat);
        check("t1.latency", 64'(lat), 64'd9);
        check_result("t1", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        handshake("t1");

        // 2: subtraction with and without borrow
        issue(32'd5, 32'd7, 1'b1);
        wait_result(lat);
        check_result("t2a", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        handshake("t2a");
        issue(32'd7, 32'd5, 1'b1);
        wait_result(lat);
        check_result("t2b", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        handshake("t2b");

        // 3: signed overflow both directions
        issue(32'h7FFF_FFFF, 32'd1, 1'b0);
        wait_result(lat);
        check_result("t3a", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        handshake("t3a");
        issue(32'h8000_0000, 32'd1, 1'b1);
        wait_result(lat);
        check_result("t3b", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        handshake("t3b");

        // 4: backpressure with competing operands on the input
        issue(32'h0000_0010, 32'h0000_0020, 1'b0);
        wait_result(lat);
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h0BAD_F00D;
        bus.sub      = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4.hold_valid", 64'(bus.out_valid), 64'd1);
            check("t4.hold_sum",   64'(bus.sum),       64'h30);
            check("t4.hold_ready", 64'(bus.in_ready),  64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("t4.idle_valid", 64'(bus.out_valid), 64'd0);
        check("t4.idle_ready", 64'(bus.in_ready),  64'd1);
        issue(32'h0000_0100, 32'h0000_0023, 1'b0);
        wait_result(lat);
        check_result("t4b", 32'h0000_0123, 1'b0, 1'b0, 1'b0);
        handshake("t4b");

        // 5: reset on the third RUN cycle aborts the op
        issue(32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5.valid", 64'(bus.out_valid), 64'd0);
        check("t5.sum",   64'(bus.sum),       64'd0);
        check("t5.ready", 64'(bus.in_ready),  64'd1);
        repeat (12) begin
            @(negedge clk);
            check("t5.no_valid", 64'(bus.out_valid), 64'd0);
        end
        issue(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_result(lat);
        check("t5.latency", 64'(lat), 64'd9);
        check_result("t5b", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        handshake("t5b");

        // 6: back-to-back with in_valid and out_ready held high
        va[0] = 32'h89AB_CDEF; vb[0] = 32'h1234_5678; vs[0] = 1'b0;
        es[0] = 32'h9BE0_2467; ec[0] = 1'b0; eo[0] = 1'b0; ez[0] = 1'b0;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; vs[1] = 1'b1;
        es[1] = 32'h0000_0000; ec[1] = 1'b1; eo[1] = 1'b0; ez[1] = 1'b1;
        va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vs[2] = 1'b0;
        es[2] = 32'h0000_0000; ec[2] = 1'b1; eo[2] = 1'b1; ez[2] = 1'b1;
        va[3] = 32'h0000_0003; vb[3] = 32'h0000_0010; vs[3] = 1'b1;
        es[3] = 32'hFFFF_FFF3; ec[3] = 1'b0; eo[3] = 1'b0; ez[3] = 1'b0;

        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        prev_edge     = 0;
        for (int i = 0; i < 4; i++) begin
            bus.a   = va[i];
            bus.b   = vb[i];
            bus.sub = vs[i];
            guard   = 0;
            while (!bus.in_ready && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            check("t6.ready", 64'(bus.in_ready), 64'd1);
            acc_edge = cyc + 1;
            if (i > 0) check("t6.spacing", 64'(acc_edge - prev_edge), 64'd10);
            prev_edge = acc_edge;
            @(posedge clk);
            @(negedge clk);
            wait_result(lat);
            check("t6.latency", 64'(lat), 64'd9);
            check_result($sformatf("t6_%0d", i), es[i], ec[i], eo[i], ez[i]);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("t6.end_valid", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
